// File: rtl/stream_xor_decrypt_if.sv
// Bundle of the control, keystream, ciphertext and plaintext signals of
// stream_xor_decrypt. The slave modport is the decryptor's view; master is
// the view of whatever surrounds it (keystream core, source and sink).
// Handshake rule for the ks, ct and pt channels: a transfer happens on a
// rising clk edge where valid && ready are both high; a source holding valid
// keeps its payload stable until that edge.
interface stream_xor_decrypt_if #(
    parameter int DATA_SIZE   = 8,
    parameter int BLOCK_BYTES = 64,
    parameter int CTR_W       = 32
);
    logic                                     start;
    logic [CTR_W-1:0]                         init_counter;
    logic                                     ks_req;
    logic [CTR_W-1:0]                         ks_counter;
    logic                                     ks_valid;
    logic                                     ks_ready;
    logic [0:BLOCK_BYTES-1][DATA_SIZE-1:0]    ks_block;
    logic                                     ct_valid;
    logic                                     ct_ready;
    logic [DATA_SIZE-1:0]                     ct_data;
    logic                                     ct_last;
    logic                                     pt_valid;
    logic                                     pt_ready;
    logic [DATA_SIZE-1:0]                     pt_data;
    logic                                     pt_last;
    logic                                     busy;
    logic                                     ctr_overflow;
    logic [2:0]                               dbg_state;

    modport slave (
        input  start, init_counter, ks_valid, ks_block,
               ct_valid, ct_data, ct_last, pt_ready,
        output ks_req, ks_counter, ks_ready, ct_ready,
               pt_valid, pt_data, pt_last, busy, ctr_overflow, dbg_state
    );

    modport master (
        output start, init_counter, ks_valid, ks_block,
               ct_valid, ct_data, ct_last, pt_ready,
        input  ks_req, ks_counter, ks_ready, ct_ready,
               pt_valid, pt_data, pt_last, busy, ctr_overflow, dbg_state
    );
endinterface

// File: rtl/stream_xor_decrypt.sv
// Byte-serial ChaCha20 decrypt stage: buffers one 64-byte keystream block,
// XORs incoming ciphertext bytes against it and presents plaintext through a
// single-entry output register. The block counter advances and a new block
// is requested each time the buffered block is used up mid-message.
// Optional feature: define STREAM_XOR_CTR_GUARD_EN to stop the message with a
// sticky ctr_overflow flag instead of letting the block counter wrap.
// dbg_state exposes the FSM state (IDLE=0 REQ=1 WAIT_KS=2 STREAM=3 DRAIN=4).
module stream_xor_decrypt #(
    parameter int DATA_SIZE   = 8,
    parameter int BLOCK_BYTES = 64,
    parameter int CTR_W       = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    stream_xor_decrypt_if.slave   bus
);
    localparam int IDX_W = $clog2(BLOCK_BYTES);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BLOCK_BYTES - 1);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        REQ     = 3'd1,
        WAIT_KS = 3'd2,
        STREAM  = 3'd3,
        DRAIN   = 3'd4
    } state_t;

    state_t                                state;
    state_t                                state_nxt;
    logic [CTR_W-1:0]                      ctr;
    logic [IDX_W-1:0]                      idx;
    logic [0:BLOCK_BYTES-1][DATA_SIZE-1:0] ks_buf;
    logic [DATA_SIZE-1:0]                  pt_data_r;
    logic                                  pt_last_r;
    logic                                  pt_valid_r;
    logic                                  ct_rdy;
    logic                                  ct_fire;
    logic                                  pt_fire;
    logic                                  ks_fire;
    logic                                  start_fire;
    logic                                  blk_end;
    logic                                  ovf_hit;

    // Handshake qualifiers; the output register accepts a byte when empty or draining.
    always_comb begin
        ct_rdy     = (state == STREAM) && (!pt_valid_r || bus.pt_ready);
        ct_fire    = bus.ct_valid && ct_rdy;
        pt_fire    = pt_valid_r && bus.pt_ready;
        ks_fire    = (state == WAIT_KS) && bus.ks_valid;
        start_fire = (state == IDLE) && bus.start;
        blk_end    = ct_fire && !bus.ct_last && (idx == LAST_IDX);
    end

`ifdef STREAM_XOR_CTR_GUARD_EN
    // Block boundary reached while the counter is at its maximum value.
    assign ovf_hit = blk_end && (ctr == {CTR_W{1'b1}});
`else
    assign ovf_hit = 1'b0;
`endif

    // Next-state decode.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (bus.start) state_nxt = REQ;
            REQ:     state_nxt = WAIT_KS;
            WAIT_KS: if (bus.ks_valid) state_nxt = STREAM;
            STREAM: begin
                if (ct_fire) begin
                    if (bus.ct_last)           state_nxt = DRAIN;
                    else if (idx == LAST_IDX)  state_nxt = ovf_hit ? DRAIN : REQ;
                end
            end
            DRAIN:   if (pt_fire) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // State, block counter and keystream byte index.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            ctr   <= '0;
            idx   <= '0;
        end else begin
            state <= state_nxt;
            if (start_fire)   ctr <= bus.init_counter;
            else if (blk_end) ctr <= ctr + CTR_W'(1);
            if (ks_fire)      idx <= '0;
            else if (ct_fire) idx <= idx + IDX_W'(1);
        end
    end

    // Keystream buffer; overwritten only when the next block is accepted.
    always_ff @(posedge clk) begin
        if (ks_fire) ks_buf <= bus.ks_block;
    end

    // Single-entry plaintext register; a load in the same cycle as a drain keeps it full.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pt_valid_r <= 1'b0;
            pt_data_r  <= '0;
            pt_last_r  <= 1'b0;
        end else if (ct_fire) begin
            pt_valid_r <= 1'b1;
            pt_data_r  <= bus.ct_data ^ ks_buf[idx];
            pt_last_r  <= bus.ct_last;
        end else if (pt_fire) begin
            pt_valid_r <= 1'b0;
        end
    end

`ifdef STREAM_XOR_CTR_GUARD_EN
    logic ovf_r;

    // Sticky wrap flag, cleared by the next accepted start.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)             ovf_r <= 1'b0;
        else if (start_fire) ovf_r <= 1'b0;
        else if (ovf_hit)    ovf_r <= 1'b1;
    end

    assign bus.ctr_overflow = ovf_r;
`else
    assign bus.ctr_overflow = 1'b0;
`endif

    assign bus.ks_req     = (state == REQ);
    assign bus.ks_ready   = (state == WAIT_KS);
    assign bus.ks_counter = ctr;
    assign bus.ct_ready   = ct_rdy;
    assign bus.pt_valid   = pt_valid_r;
    assign bus.pt_data    = pt_data_r;
    assign bus.pt_last    = pt_last_r;
    assign bus.busy       = (state != IDLE);
    assign bus.dbg_state  = state;
endmodule

// File: tb/tb_stream_xor_decrypt.sv
// Bench for stream_xor_decrypt: random messages checked against a model that
// derives plaintext, request counters and cycle timing from the message length,
// the starting counter and the keystream blocks it hands out.
module tb_stream_xor_decrypt;
    localparam int DW  = 8;
    localparam int BB  = 64;
    localparam int CW  = 32;
`ifdef STREAM_XOR_CTR_GUARD_EN
    localparam bit GUARD = 1'b1;
`else
    localparam bit GUARD = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    stream_xor_decrypt_if #(.DATA_SIZE(DW), .BLOCK_BYTES(BB), .CTR_W(CW)) bus ();

    stream_xor_decrypt #(.DATA_SIZE(DW), .BLOCK_BYTES(BB), .CTR_W(CW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Clock: rising edges at 5, 15, ...; inputs change on falling edges.
    always #5 clk = ~clk;

    task automatic idle_inputs();
        bus.start        = 1'b0;
        bus.init_counter = '0;
        bus.ks_valid     = 1'b0;
        bus.ks_block     = '0;
        bus.ct_valid     = 1'b0;
        bus.ct_data      = '0;
        bus.ct_last      = 1'b0;
        bus.pt_ready     = 1'b0;
    endtask

    // Runs one message. mode 0: no gaps, pt_ready high; 1: pt_ready toggles;
    // 2: random gaps and delays. pat 1: ct byte i = i, keystream 0xA5.
    // abort_at > 0 leaves the loop once that many ct bytes are accepted.
    task automatic run_msg(input int len, input logic [CW-1:0] init_ctr, input int mode,
                           input int pat, input int abort_at, input bit spurious_start);
        logic [DW-1:0] ct_arr[$];
        logic [DW-1:0] ks_arr[$];
        logic [DW-1:0] exp_q[$];
        logic          exp_last_q[$];
        logic [CW-1:0] exp_req_q[$];
        logic [CW-1:0] c;
        logic [DW-1:0] e_d;
        logic [CW-1:0] e_c;
        logic          e_l;
        int nblk, n_pt, n_req_exp, cyc, ct_i, ks_served, n_req, n_pt_seen;
        int first_pt_cyc, last_pt_cyc, done_cyc, ks_delay;
        bit ks_pend, ct_hold, done, aborted, ovf_exp;

        // Reference model: block b serves bytes 64b..64b+63 with counter init+b.
        nblk = (len + BB - 1) / BB;
        c = init_ctr;
        n_pt = len;
        ovf_exp = 1'b0;
        for (int b = 0; b < nblk; b++) begin
            exp_req_q.push_back(c);
            if (b < nblk - 1) begin
                if (GUARD && c == {CW{1'b1}}) begin
                    n_pt = BB * (b + 1);
                    ovf_exp = 1'b1;
                    break;
                end
                c = c + 1;
            end
        end
        n_req_exp = exp_req_q.size();
        for (int i = 0; i < nblk * BB; i++)
            ks_arr.push_back(pat == 1 ? 8'hA5 : DW'($urandom_range(0, 255)));
        for (int i = 0; i < len; i++)
            ct_arr.push_back(pat == 1 ? DW'(i) : DW'($urandom_range(0, 255)));
        for (int i = 0; i < n_pt; i++) begin
            exp_q.push_back(ct_arr[i] ^ ks_arr[i]);
            exp_last_q.push_back(i == len - 1);
        end

        cyc = 0; ct_i = 0; ks_served = 0; n_req = 0; n_pt_seen = 0;
        first_pt_cyc = -1; last_pt_cyc = -1; done_cyc = -1; ks_delay = 0;
        ks_pend = 0; ct_hold = 0; done = 0; aborted = 0;

        while (!done && cyc < 3000) begin
            @(negedge clk);
            bus.start        = (cyc == 0) || (spurious_start && cyc >= 2 && cyc <= 4);
            bus.init_counter = (cyc == 0) ? init_ctr : ~init_ctr;
            case (mode)
                0:       bus.pt_ready = 1'b1;
                1:       bus.pt_ready = cyc[0];
                default: bus.pt_ready = ($urandom_range(0, 2) != 0);
            endcase
            if (!ct_hold && ct_i < len && (mode != 2 || $urandom_range(0, 3) != 0))
                ct_hold = 1'b1;
            bus.ct_valid = ct_hold;
            bus.ct_data  = ct_hold ? ct_arr[ct_i] : DW'($urandom_range(0, 255));
            bus.ct_last  = ct_hold ? (ct_i == len - 1) : 1'($urandom_range(0, 1));
            bus.ks_valid = 1'b0;
            if (ks_pend) begin
                if (ks_delay > 0) ks_delay--;
                else begin
                    bus.ks_valid = 1'b1;
                    for (int j = 0; j < BB; j++)
                        bus.ks_block[j] = (ks_served < nblk) ? ks_arr[ks_served * BB + j] : 8'h00;
                end
            end
            #4;
            if (bus.ks_req) begin
                checks++;
                if (exp_req_q.size() == 0) begin
                    errors++;
                    $display("FAIL ks_req_extra: got request for ctr %h, expected none", bus.ks_counter);
                end else begin
                    e_c = exp_req_q.pop_front();
                    if (bus.ks_counter !== e_c) begin
                        errors++;
                        $display("FAIL ks_counter: got %h, expected %h", bus.ks_counter, e_c);
                    end
                end
                if (n_req == 0) begin
                    checks++;
                    if (cyc != 1) begin
                        errors++;
                        $display("FAIL start_to_req: ks_req in cycle %0d, expected 1", cyc);
                    end
                end
                n_req++;
                ks_pend  = 1'b1;
                ks_delay = (mode == 2) ? $urandom_range(0, 3) : 0;
            end
            if (bus.ks_valid && bus.ks_ready) begin
                ks_served++;
                ks_pend = 1'b0;
            end
            if (bus.pt_valid && !bus.pt_ready) begin
                checks++;
                if (bus.ct_ready !== 1'b0) begin
                    errors++;
                    $display("FAIL ct_ready_bp: got %b while pt stalled, expected 0", bus.ct_ready);
                end
            end
            if (bus.ct_valid && bus.ct_ready) begin
                ct_i++;
                ct_hold = 1'b0;
            end
            if (bus.pt_valid && bus.pt_ready) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL pt_extra: got byte %h, expected none", bus.pt_data);
                end else begin
                    e_d = exp_q.pop_front();
                    e_l = exp_last_q.pop_front();
                    if (bus.pt_data !== e_d || bus.pt_last !== e_l) begin
                        errors++;
                        $display("FAIL pt_byte%0d: got %h last %b, expected %h last %b",
                                 n_pt_seen, bus.pt_data, bus.pt_last, e_d, e_l);
                    end
                end
                if (n_pt_seen == 0) first_pt_cyc = cyc;
                last_pt_cyc = cyc;
                n_pt_seen++;
            end
            if (abort_at > 0 && ct_i == abort_at) begin
                aborted = 1'b1;
                done = 1'b1;
            end else if (n_pt_seen == n_pt && !bus.busy) begin
                done = 1'b1;
                done_cyc = cyc;
            end
            cyc++;
        end

        if (!aborted) begin
            checks++;
            if (!done) begin
                errors++;
                $display("FAIL timeout: %0d of %0d pt bytes after %0d cycles", n_pt_seen, n_pt, cyc);
            end
            checks++;
            if (n_req != n_req_exp) begin
                errors++;
                $display("FAIL req_count: got %0d requests, expected %0d", n_req, n_req_exp);
            end
            checks++;
            if (exp_q.size() != 0) begin
                errors++;
                $display("FAIL pt_missing: %0d bytes never delivered, expected 0", exp_q.size());
            end
            checks++;
            if (bus.ctr_overflow !== ovf_exp) begin
                errors++;
                $display("FAIL ctr_overflow: got %b, expected %b", bus.ctr_overflow, ovf_exp);
            end
            if (mode == 0) begin
                checks++;
                if (first_pt_cyc != 4 || last_pt_cyc != 3 + n_pt + 2 * (n_req_exp - 1)
                    || done_cyc != last_pt_cyc + 1) begin
                    errors++;
                    $display("FAIL timing: first/last/idle cycles %0d/%0d/%0d, expected 4/%0d/%0d",
                             first_pt_cyc, last_pt_cyc, done_cyc,
                             3 + n_pt + 2 * (n_req_exp - 1), 4 + n_pt + 2 * (n_req_exp - 1));
                end
            end
        end
        @(negedge clk);
        idle_inputs();
    endtask

    task automatic test_reset();
        logic [63:0] obs;
        idle_inputs();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        obs = {bus.ks_req, bus.ks_ready, bus.ks_counter, bus.ct_ready, bus.pt_valid,
               bus.pt_data, bus.pt_last, bus.busy, bus.ctr_overflow, bus.dbg_state, 13'd0};
        checks++;
        if (obs !== 64'd0) begin
            errors++;
            $display("FAIL reset_values: got %h, expected all zero", obs);
        end
        @(negedge clk);
        rst = 1'b0;
        bus.ks_valid = 1'b1;
        repeat (3) @(negedge clk);
        #4;
        checks++;
        if (bus.ks_ready !== 1'b0 || bus.busy !== 1'b0) begin
            errors++;
            $display("FAIL ks_in_idle: ks_ready %b busy %b, expected 0 0", bus.ks_ready, bus.busy);
        end
        @(negedge clk);
        idle_inputs();
    endtask

    task automatic test_single_block();
        run_msg(64, 32'd1, 0, 1, 0, 1'b0);
    endtask

    task automatic test_block_boundary();
        run_msg(100, 32'd7, 0, 0, 0, 1'b0);
    endtask

    task automatic test_backpressure();
        run_msg(150, 32'($urandom), 1, 0, 0, 1'b0);
    endtask

    task automatic test_short_message();
        run_msg(3, 32'h0000_0100, 0, 0, 0, 1'b1);
    endtask

    task automatic test_counter_wrap();
        run_msg(70, 32'hFFFF_FFFF, 0, 0, 0, 1'b0);
    endtask

    task automatic test_reset_mid_stream();
        logic [63:0] obs;
        run_msg(100, 32'h1234_5678, 0, 0, 20, 1'b0);
        #2;
        rst = 1'b1;
        #1;
        obs = {bus.ks_req, bus.ks_ready, bus.ks_counter, bus.ct_ready, bus.pt_valid,
               bus.pt_data, bus.pt_last, bus.busy, bus.ctr_overflow, bus.dbg_state, 13'd0};
        checks++;
        if (obs !== 64'd0) begin
            errors++;
            $display("FAIL reset_mid_stream: got %h, expected all zero", obs);
        end
        @(negedge clk);
        rst = 1'b0;
        run_msg(10, 32'h0000_0042, 0, 0, 0, 1'b0);
    endtask

    task automatic test_random();
        for (int m = 0; m < 5; m++)
            run_msg($urandom_range(1, 200), 32'($urandom), 2, 0, 0, 1'b0);
    endtask

    initial begin
        idle_inputs();
        test_reset();
        test_single_block();
        test_block_boundary();
        test_backpressure();
        test_short_message();
        test_counter_wrap();
        test_reset_mid_stream();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/stream_xor_decrypt.md
# stream_xor_decrypt

Byte-serial ChaCha20 decryption datapath: accepts ciphertext one byte per handshake, XORs it with the matching byte of a buffered 64-byte keystream block, and emits plaintext one byte per handshake. It is the receive-side counterpart of the block-parallel encryption XOR stage. It sits between the ChaCha20 core (keystream source) and the downstream plaintext consumer. It tracks the block counter and requests each new keystream block as the previous one is exhausted.

## Interface
- DATA_SIZE, 8, byte width
- BLOCK_BYTES, 64, keystream bytes per block
- CTR_W, 32, block counter width
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- start  in  1  begin a message; sampled only in IDLE
- init_counter  in  CTR_W  starting block counter, latched on start
- ks_req  out  1  one-cycle pulse requesting keystream for ks_counter
- ks_counter  out  CTR_W  block counter of the requested/current block
- ks_valid  in  1  keystream block present
- ks_ready  out  1  block accepted when ks_valid && ks_ready
- ks_block  in  DATA_SIZE x [0:BLOCK_BYTES-1]  keystream block, byte 0 first
- ct_valid, ct_ready  in/out  1  ciphertext handshake
- ct_data  in  DATA_SIZE  ciphertext byte
- ct_last  in  1  final byte of message
- pt_valid, pt_ready  out/in  1  plaintext handshake
- pt_data  out  DATA_SIZE  plaintext byte
- pt_last  out  1  final plaintext byte
- busy  out  1  high in any state other than IDLE
- ctr_overflow  out  1  sticky counter-wrap flag (see Configuration)

## Operation
- States: IDLE, REQ, WAIT_KS, STREAM, DRAIN.
- IDLE: on start, ctr <= init_counter, clear ctr_overflow, go to REQ. Start outside IDLE is ignored.
- REQ: ks_req = 1 for exactly one cycle, then go to WAIT_KS.
- WAIT_KS: ks_ready = 1. On ks_valid, latch all BLOCK_BYTES bytes into the internal buffer, idx <= 0, go to STREAM.
- STREAM:
  - ct_ready = !pt_valid || pt_ready (single-entry output register).
  - On ct accept: pt_data <= ct_data ^ ks_buf[idx]; pt_last <= ct_last; pt_valid <= 1; idx <= idx+1.
  - If ct_last, go to DRAIN. No further request is issued, even if the block ends there.
  - Else if idx == BLOCK_BYTES-1, ctr <= ctr+1 and go to REQ.
- DRAIN: ct_ready = 0. When the pt output handshake completes, go to IDLE.
- ct_ready = 0 in IDLE, REQ, WAIT_KS and DRAIN. A pending pt byte still drains in REQ and WAIT_KS.
- pt_valid clears on pt_valid && pt_ready unless a new byte loads in the same cycle; simultaneous load and drain keeps pt_valid = 1.
- Counter arithmetic is modulo 2^CTR_W. ks_counter = ctr.
- Plaintext is stored nowhere beyond the output register; keystream is held only until the next block loads.

## Timing
- Reset values: ks_req 0, ks_ready 0, ks_counter 0, ct_ready 0, pt_valid 0, pt_data 0, pt_last 0, busy 0, ctr_overflow 0; state IDLE; idx 0.
- rst at any point aborts the message immediately. A partially transferred pt byte is dropped.
- start at edge N: ks_req high in cycle N+1.
- ks accept at edge M: ct_ready can be high in cycle M+1.
- Latency: ct accepted at edge K, pt_valid high after edge K (1 cycle).
- Throughput: 1 byte/cycle within a block with pt_ready held high. Each block boundary costs ≥2 bubble cycles (REQ + WAIT_KS).
- ks_ready is never high outside WAIT_KS. A ks_valid outside WAIT_KS is ignored.

## Configuration
- STREAM_XOR_CTR_GUARD_EN defined:
  - An increment from 2^CTR_W-1 sets ctr_overflow, skips REQ, and enters DRAIN.
  - Remaining ct is refused until the next start; ctr_overflow clears on that start or on rst.
- STREAM_XOR_CTR_GUARD_EN undefined: the counter wraps to 0 silently and ctr_overflow is tied 0.

## Test plan
- Single block: start with init_counter=1, 64 ct bytes 0x00..0x3F, ks byte i = 0xA5, pt_ready=1, ct_last on byte 63 -> pt byte i = i^0xA5; pt_last on byte 63; exactly one ks_req; busy falls after the pt_last handshake.
- Block boundary: 100-byte message, init_counter=7 -> ks_req pulses with ks_counter 7 then 8; pt bytes 64..99 use the second block; no further request after ct_last.
- Backpressure: pt_ready toggling 1/0 every cycle -> no byte lost or duplicated; ct_ready low whenever pt_valid && !pt_ready.
- Short message: 3 bytes, ct_last on byte 2 -> 3 pt bytes with pt_last on the third; IDLE after drain; start ignored while busy.
- Reset mid-stream: assert rst after byte 20 -> all outputs at reset values in the same cycle; a new start restarts at init_counter.
- Counter wrap: init_counter=0xFFFFFFFF, 70 bytes. With the macro: ctr_overflow=1 after byte 63 and no second ks_req. Without the macro: second ks_req with ks_counter=0.
